// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants for the VGA pixel-write path: coordinate and
//            colour widths, screen bounds, requester indices, and an
//            index-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;

  // Fixed requester slots on the arbiter
  localparam int REQ_CLEAR    = 0;
  localparam int REQ_START    = 1;
  localparam int REQ_GAMEOVER = 2;
  localparam int REQ_OBJECTS  = 3;

  // Bits needed to index n items. The result is never below 1, so a
  // two-entry index still gets a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. It rotates the request vector
//            so that 'start' lands at bit 0, isolates the lowest set bit, then
//            rotates the result back to its original position.
// Ports    : vec    - request vector (N bits)
//            start  - index that has the highest priority
//            onehot - selected request (one-hot, zero if none)
//            found  - at least one request bit was set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import vga_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          vec,
  input  logic [clog2(N)-1:0]   start,
  output logic [N-1:0]          onehot,
  output logic                  found
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_ffs;

  // Rotate: w_rot[j] is the request that sits j places above 'start'.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++) begin
      w_rot[j] = vec[(int'(start) + j) % N];
    end
  end

  // Keep only the lowest set bit of the rotated vector.
  assign w_ffs = w_rot & (~w_rot + 1'b1);
  assign found = |w_rot;

  // Un-rotate back to the original requester positions.
  always_comb begin
    onehot = '0;
    for (int j = 0; j < N; j++) begin
      onehot[(int'(start) + j) % N] = w_ffs[j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_write_arbiter
// Purpose  : Shares the single VGA adapter pixel-write port among all screen
//            painters. Arbitration is round-robin, with a per-requester
//            enable and an ownership lock for full-screen bursts. The
//            adapter-facing outputs pass through one register stage.
// Ports    : clk, resetn (async, active low), abort (sync flush)
//            req_en/req/req_lock  - per-requester enable, request, lock
//            req_x/req_y/req_colour - packed per-requester pixel data
//            gnt          - one-hot combinational accept
//            owner/lock_active - current lock holder
//            plot/vga_x/vga_y/vga_colour - registered adapter write
//            oob_drop     - accepted pixel was off-screen and discarded
//            busy         - enabled request pending or write in flight
// Revision : 1.0 - initial release
// ============================================================================
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W   = vga_pkg::X_W,
  parameter int Y_W   = vga_pkg::Y_W,
  parameter int C_W   = vga_pkg::C_W,
  parameter int X_MAX = vga_pkg::X_MAX,
  parameter int Y_MAX = vga_pkg::Y_MAX
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      abort,
  input  logic [N_REQ-1:0]          req_en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*X_W-1:0]      req_x,
  input  logic [N_REQ*Y_W-1:0]      req_y,
  input  logic [N_REQ*C_W-1:0]      req_colour,
  output logic [N_REQ-1:0]          gnt,
  output logic [clog2(N_REQ)-1:0]   owner,
  output logic                      lock_active,
  output logic                      plot,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [C_W-1:0]            vga_colour,
  output logic                      oob_drop,
  output logic                      busy
);

  localparam int c_iw = clog2(N_REQ);
  // One extra bit so the bound itself is representable even when it equals 2**W.
  localparam logic [X_W:0] c_x_max = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] c_y_max = (Y_W+1)'(Y_MAX);

  logic [N_REQ-1:0] w_eff, w_pick, w_gnt;
  logic             w_found, w_xfer, w_release, w_in_range;
  logic [c_iw-1:0]  r_ptr, r_owner, w_gnt_idx;
  logic [c_iw-1:0]  w_ptr_nxt, w_owner_nxt;
  logic             r_lock, w_lock_nxt;
  logic [X_W-1:0]   w_x, r_x;
  logic [Y_W-1:0]   w_y, r_y;
  logic [C_W-1:0]   w_c, r_c;
  logic             r_plot, r_oob;

  function automatic logic [c_iw-1:0] f_inc(input logic [c_iw-1:0] i);
    return (i == c_iw'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign w_eff = req & req_en;

  rr_pick #(.N(N_REQ)) u_pick (
    .vec    (w_eff),
    .start  (r_ptr),
    .onehot (w_pick),
    .found  (w_found)
  );

  // While locked, only the owner can win. Because w_eff already includes
  // req_en, an owner whose enable drops is not granted.
  always_comb begin
    w_gnt = '0;
    if (!abort) begin
      if (r_lock) begin
        if (w_eff[r_owner]) w_gnt[r_owner] = 1'b1;
      end else if (w_found) begin
        w_gnt = w_pick;
      end
    end
  end

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_gnt_idx = c_iw'(i);
    end
  end

  assign w_xfer    = |w_gnt;
  assign w_release = r_lock & (~req_lock[r_owner] | ~req_en[r_owner]);

  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock;
    w_owner_nxt = r_owner;
    if (abort) begin
      w_ptr_nxt   = '0;
      w_lock_nxt  = 1'b0;
      w_owner_nxt = '0;
    end else if (r_lock) begin
      // The pointer stays frozen until release, then resumes after the owner.
      if (w_release) begin
        w_ptr_nxt   = f_inc(r_owner);
        w_lock_nxt  = 1'b0;
        w_owner_nxt = '0;
      end
    end else if (w_xfer) begin
      w_ptr_nxt = f_inc(w_gnt_idx);
      if (req_lock[w_gnt_idx]) begin
        w_lock_nxt  = 1'b1;
        w_owner_nxt = w_gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr   <= '0;
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_lock  <= w_lock_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Pixel data of the granted requester
  assign w_x = req_x[int'(w_gnt_idx)*X_W +: X_W];
  assign w_y = req_y[int'(w_gnt_idx)*Y_W +: Y_W];
  assign w_c = req_colour[int'(w_gnt_idx)*C_W +: C_W];
  assign w_in_range = ({1'b0, w_x} < c_x_max) && ({1'b0, w_y} < c_y_max);

  // Off-screen pixels are discarded and leave the last good coordinates
  // on the bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_plot <= 1'b0;
      r_oob  <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= '0;
    end else if (w_xfer) begin
      r_plot <= w_in_range;
      r_oob  <= ~w_in_range;
      if (w_in_range) begin
        r_x <= w_x;
        r_y <= w_y;
        r_c <= w_c;
      end
    end else begin
      r_plot <= 1'b0;
      r_oob  <= 1'b0;
    end
  end

  assign gnt         = w_gnt;
  assign owner       = r_owner;
  assign lock_active = r_lock;
  assign plot        = r_plot;
  assign vga_x       = r_x;
  assign vga_y       = r_y;
  assign vga_colour  = r_c;
  assign oob_drop    = r_oob;
  assign busy        = (|w_eff) | r_plot;

endmodule
`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_write_arbiter
// Purpose  : Self-checking bench for vga_write_arbiter. It keeps a
//            behavioural reference model and runs one task per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_write_arbiter;
  import vga_pkg::*;

  localparam int N = 4;

  logic        clk, resetn, abort;
  logic [3:0]  req_en, req, req_lock, gnt;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [1:0]  owner;
  logic        lock_active, plot, oob_drop, busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  vga_write_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .resetn(resetn), .abort(abort), .req_en(req_en), .req(req),
    .req_lock(req_lock), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .gnt(gnt), .owner(owner), .lock_active(lock_active), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .oob_drop(oob_drop), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pixel each requester is currently presenting
  int px[N], py[N], pc[N];

  // Reference model state
  int         m_ptr, m_owner;
  logic       m_lock, m_plot, m_oob;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_x[i*8 +: 8]      = 8'(px[i]);
      req_y[i*7 +: 7]      = 7'(py[i]);
      req_colour[i*3 +: 3] = 3'(pc[i]);
    end
  endtask

  task automatic new_pixel(input int i, input bit allow_oob);
    px[i] = allow_oob ? $urandom_range(0, 200) : $urandom_range(0, X_MAX-1);
    py[i] = allow_oob ? $urandom_range(0, 127) : $urandom_range(0, Y_MAX-1);
    pc[i] = $urandom_range(0, 7);
    pack();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_lock = 0; m_plot = 0; m_oob = 0;
    m_x = '0; m_y = '0; m_c = '0;
  endtask

  // Expected grant: first enabled request at or after the pointer, or only
  // the owner while a lock is held.
  function automatic logic [3:0] model_gnt();
    logic [3:0] eff, g;
    eff = req & req_en;
    g = '0;
    if (abort) return g;
    if (m_lock) begin
      if (eff[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      if (eff[(m_ptr + k) % N]) begin
        g[(m_ptr + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(input logic [3:0] g);
    int w;
    w = -1;
    for (int k = 0; k < N; k++) if (g[k]) w = k;
    if (abort) begin
      m_ptr = 0; m_lock = 0; m_owner = 0; m_plot = 0; m_oob = 0;
      return;
    end
    if (w >= 0) begin
      if (px[w] < X_MAX && py[w] < Y_MAX) begin
        m_x = 8'(px[w]); m_y = 7'(py[w]); m_c = 3'(pc[w]);
        m_plot = 1; m_oob = 0;
      end else begin
        m_plot = 0; m_oob = 1;
      end
    end else begin
      m_plot = 0; m_oob = 0;
    end
    if (m_lock) begin
      if (!req_lock[m_owner] || !req_en[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_lock = 0; m_owner = 0;
      end
    end else if (w >= 0) begin
      m_ptr = (w + 1) % N;
      if (req_lock[w]) begin m_lock = 1; m_owner = w; end
    end
  endtask

  // Move the model across one clock edge and settle past it.
  task automatic advance(input logic [3:0] g);
    @(posedge clk);
    model_edge(g);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; req_lock = '0; req_en = 4'hf; abort = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < N; i++) new_pixel(i, 0);
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({plot, oob_drop, lock_active, owner, vga_x, vga_y, vga_colour} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {plot, oob_drop, lock_active, owner, vga_x, vga_y, vga_colour});
    end
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt_busy: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    resetn = 1'b1;
    #2;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    req = 4'hf; req_en = 4'hf; req_lock = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = model_gnt();
      checks++;
      if (gnt !== 4'(1 << (k % 4)) || gnt !== exp) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, 4'(1 << (k % 4)));
      end
      advance(exp);
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'(px[k % 4]) || vga_y !== m_y || vga_colour !== m_c) begin
        errors++;
        $display("FAIL rr_out[%0d]: got plot=%b x=%0d expected plot=1 x=%0d", k, plot, vga_x, px[k % 4]);
      end
      new_pixel(k % 4, 0);
    end
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    logic [3:0] exp;
    bit         r1;
    int         n;
    int         bad;
    bad = 0;
    idle_inputs();
    abort = 1'b1;             // park the pointer at 0
    #1; advance(model_gnt());
    abort = 1'b0;
    r1 = 1'($urandom);
    req = 4'b1000 | 4'b0001 | {2'b00, r1, 1'b0};
    req_lock = 4'b0001;
    new_pixel(REQ_OBJECTS, 0);
    for (n = 0; n < X_MAX*Y_MAX; n++) begin
      px[REQ_CLEAR] = n % X_MAX; py[REQ_CLEAR] = n / X_MAX; pc[REQ_CLEAR] = n % 8;
      pack();
      if (n == X_MAX*Y_MAX - 1) req_lock[REQ_CLEAR] = 1'b0;
      #1;
      exp = model_gnt();
      checks++;
      if (gnt !== 4'b0001 || gnt !== exp) begin
        errors++;
        if (bad++ < 5) $display("FAIL burst_gnt[%0d]: got %b expected 0001", n, gnt);
      end
      advance(exp);
      checks++;
      if ({plot, lock_active, owner, vga_x, vga_y, vga_colour} !==
          {m_plot, m_lock, 2'(m_owner), m_x, m_y, m_c}) begin
        errors++;
        if (bad++ < 5) $display("FAIL burst_out[%0d]: got %h expected %h", n,
          {plot, lock_active, owner, vga_x, vga_y, vga_colour},
          {m_plot, m_lock, 2'(m_owner), m_x, m_y, m_c});
      end
    end
    checks++;
    if (lock_active !== 1'b0) begin
      errors++;
      $display("FAIL burst_release: got lock_active=%b expected 0", lock_active);
    end
    req[REQ_CLEAR] = 1'b0;
    #1;
    exp = model_gnt();
    checks++;
    if (gnt !== (r1 ? 4'b0010 : 4'b1000) || gnt !== exp) begin
      errors++;
      $display("FAIL burst_next: got %b expected %b", gnt, r1 ? 4'b0010 : 4'b1000);
    end
    advance(exp);
    idle_inputs();
  endtask

  task automatic test_oob();
    logic [3:0] exp;
    logic [7:0] x0;
    logic [6:0] y0;
    idle_inputs();
    x0 = vga_x; y0 = vga_y;
    req = 4'b0100;
    px[REQ_GAMEOVER] = 160; py[REQ_GAMEOVER] = 5; pc[REQ_GAMEOVER] = 6; pack();
    #1; exp = model_gnt();
    advance(exp);
    checks++;
    if (plot !== 1'b0 || oob_drop !== 1'b1 || vga_x !== x0 || vga_y !== y0) begin
      errors++;
      $display("FAIL oob_drop: got plot=%b oob=%b x=%0d y=%0d expected 0/1/%0d/%0d",
               plot, oob_drop, vga_x, vga_y, x0, y0);
    end
    px[REQ_GAMEOVER] = 159; py[REQ_GAMEOVER] = 119; pc[REQ_GAMEOVER] = 5; pack();
    #1; exp = model_gnt();
    advance(exp);
    checks++;
    if (plot !== 1'b1 || oob_drop !== 1'b0 || vga_x !== 8'd159 || vga_y !== 7'd119 || vga_colour !== 3'd5) begin
      errors++;
      $display("FAIL oob_edge: got plot=%b oob=%b x=%0d y=%0d c=%0d expected 1/0/159/119/5",
               plot, oob_drop, vga_x, vga_y, vga_colour);
    end
    req = '0;
    #1; advance(model_gnt());
    checks++;
    if (plot !== 1'b0 || oob_drop !== 1'b0 || vga_x !== 8'd159) begin
      errors++;
      $display("FAIL oob_idle: got plot=%b oob=%b x=%0d expected 0/0/159", plot, oob_drop, vga_x);
    end
  endtask

  task automatic test_en_drop();
    logic [3:0] exp;
    idle_inputs();
    abort = 1'b1;
    #1; advance(model_gnt());
    abort = 1'b0;
    req = 4'b0010; req_lock = 4'b0010;
    new_pixel(REQ_START, 0);
    #1; exp = model_gnt();
    advance(exp);
    req = 4'hf;
    for (int k = 0; k < 3; k++) begin
      new_pixel(REQ_START, 0);
      #1; exp = model_gnt();
      checks++;
      if (gnt !== 4'b0010 || lock_active !== 1'b1 || owner !== 2'd1) begin
        errors++;
        $display("FAIL endrop_locked[%0d]: got gnt=%b lock=%b owner=%0d expected 0010/1/1",
                 k, gnt, lock_active, owner);
      end
      advance(exp);
    end
    req_en[REQ_START] = 1'b0;
    #1; exp = model_gnt();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL endrop_gnt: got %b expected 0000", gnt);
    end
    advance(exp);
    checks++;
    if (lock_active !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL endrop_release: got lock=%b owner=%0d expected 0/0", lock_active, owner);
    end
    req_en = 4'hf; req_lock = '0;
    #1; exp = model_gnt();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL endrop_ptr: got %b expected 0100", gnt);
    end
    advance(exp);
    idle_inputs();
  endtask

  task automatic test_abort();
    logic [3:0] exp;
    idle_inputs();
    req = 4'b1000; req_lock = 4'b1000;   // hold a lock so abort has something to clear
    #1; advance(model_gnt());
    req = 4'b0110; abort = 1'b1;
    #1; exp = model_gnt();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL abort_gnt: got %b expected 0000", gnt);
    end
    advance(exp);
    checks++;
    if (plot !== 1'b0 || oob_drop !== 1'b0 || lock_active !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL abort_state: got plot=%b oob=%b lock=%b owner=%0d expected 0/0/0/0",
               plot, oob_drop, lock_active, owner);
    end
    abort = 1'b0; req_lock = '0;
    #1; exp = model_gnt();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL abort_resume: got %b expected 0010", gnt);
    end
    advance(exp);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    req = 4'b0100; req_lock = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      new_pixel(REQ_GAMEOVER, 0);
      #1; advance(model_gnt());
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b0 || lock_active !== 1'b0 || owner !== 2'd0 || vga_x !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got plot=%b lock=%b owner=%0d x=%0d expected 0/0/0/0",
               plot, lock_active, owner, vga_x);
    end
    idle_inputs();
    model_reset();
    #1 resetn = 1'b1;
    advance(model_gnt());
  endtask

  task automatic test_random();
    logic [3:0] exp;
    logic       exp_busy;
    int         bad;
    bad = 0;
    for (int i = 0; i < N; i++) new_pixel(i, 1);
    for (int n = 0; n < 3000; n++) begin
      req      = 4'($urandom);
      req_en   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hf;
      req_lock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      abort    = ($urandom_range(0, 49) == 0);
      #1;
      exp = model_gnt();
      exp_busy = (|(req & req_en)) | m_plot;
      checks++;
      if (gnt !== exp || busy !== exp_busy) begin
        errors++;
        if (bad++ < 8) $display("FAIL rand_gnt[%0d]: got gnt=%b busy=%b expected %b/%b",
                                n, gnt, busy, exp, exp_busy);
      end
      advance(exp);
      checks++;
      if ({plot, oob_drop, lock_active, owner, vga_x, vga_y, vga_colour} !==
          {m_plot, m_oob, m_lock, 2'(m_owner), m_x, m_y, m_c}) begin
        errors++;
        if (bad++ < 8) $display("FAIL rand_out[%0d]: got %h expected %h", n,
          {plot, oob_drop, lock_active, owner, vga_x, vga_y, vga_colour},
          {m_plot, m_oob, m_lock, 2'(m_owner), m_x, m_y, m_c});
      end
      for (int i = 0; i < N; i++) if (exp[i]) new_pixel(i, 1);
    end
    idle_inputs();
  endtask

  initial begin
    req_x = '0; req_y = '0; req_colour = '0;
    resetn = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_round_robin();
    test_oob();
    test_en_drop();
    test_abort();
    test_lock_burst();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (plot/x/y/colour) among all screen painters: clear_display, startscreen_display, gameover_display and the in-game object renderer.
- Uses round-robin arbitration with per-requester enables driven by the game state controller.
- Supports a lock so a full-screen paint can hold the port for a whole burst.
- Sits between the painters and the VGA adapter, with a 1-cycle registered output stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- X_MAX, 160, screen width; valid x is 0..X_MAX-1.
- Y_MAX, 120, screen height; valid y is 0..Y_MAX-1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- abort  in  1  synchronous pulse (driven from game_reset); flushes arbiter state
- req_en  in  N_REQ  per-requester enable mask; a request is ignored while its bit is 0
- req  in  N_REQ  pixel-write request per requester
- req_lock  in  N_REQ  requester wants to keep ownership after its grant
- req_x  in  N_REQ*X_W  packed x; requester i occupies slice [i*X_W +: X_W]
- req_y  in  N_REQ*Y_W  packed y
- req_colour  in  N_REQ*C_W  packed colour
- gnt  out  N_REQ  one-hot accept (combinational); at most one bit high
- owner  out  clog2(N_REQ)  index of the current lock owner; 0 when no lock is held
- lock_active  out  1  a lock is currently held
- plot  out  1  registered VGA write strobe
- vga_x  out  X_W  registered x
- vga_y  out  Y_W  registered y
- vga_colour  out  C_W  registered colour
- oob_drop  out  1  registered 1-cycle pulse: the accepted pixel was out of range and was discarded
- busy  out  1  any enabled request pending, or plot high

Behaviour:
- Reset (resetn=0, asynchronous): pointer=0, lock_active=0, owner=0, plot=0, vga_x/vga_y/vga_colour=0, oob_drop=0.
- Effective request: eff[i] = req[i] & req_en[i].
- Handshake:
  - A requester holds req and its x/y/colour stable until it sees gnt[i]=1.
  - A clock edge with gnt[i]=1 is a transfer; the requester may present its next pixel in the following cycle.
  - gnt is a combinational function of eff, abort, the pointer and lock state. It never depends on plot, so there is no backpressure from the adapter.
- Arbitration when unlocked:
  - Pick the first i with eff[i]=1, searching from pointer upward and wrapping modulo N_REQ.
  - After a transfer from i, pointer becomes (i+1) mod N_REQ.
  - If no eff bit is set, gnt=0 and the pointer is held.
- Locking:
  - A transfer from i with req_lock[i]=1 sets lock_active=1 and owner=i.
  - While locked, only eff[owner] can be granted; all other requests are blocked. The pointer is frozen.
  - Release happens at the clock edge where req_lock[owner]=0 or req_en[owner]=0. It also happens on a locked cycle with eff[owner]=0 where req_lock[owner]=0.
  - A transfer with req_lock[owner]=0 is granted and releases the lock in the same edge.
  - On release the pointer becomes (owner+1) mod N_REQ and owner returns to 0.
  - If req_en[owner] drops, gnt to the owner is suppressed that cycle and the lock releases at the edge.
- Output stage:
  - Each transfer registers x/y/colour into vga_*.
  - plot=1 in the next cycle if x<X_MAX and y<Y_MAX.
  - Otherwise plot=0, oob_drop=1 for one cycle, and vga_* are left unchanged.
  - Without a transfer, plot=0 and vga_* hold their values.
  - Latency from transfer to plot is exactly 1 cycle. Sustained throughput is 1 pixel per cycle.
- abort:
  - Has priority over everything: gnt=0 in that cycle.
  - At the edge: pointer=0, lock_active=0, owner=0, plot=0, oob_drop=0.
  - vga_* hold their values.
- Reset asserted mid-burst: all state is cleared immediately. After reset, the requester must re-request; no partial state survives.

Decomposition:
- Shared package vga_pkg:
  - X_W, Y_W, C_W, X_MAX, Y_MAX.
  - Requester index constants: REQ_CLEAR=0, REQ_START=1, REQ_GAMEOVER=2, REQ_OBJECTS=3.
  - Index width function clog2.
- Sub-module rr_pick: a combinational rotate / find-first-set / un-rotate.
  - Inputs: N_REQ-bit vector and start pointer.
  - Outputs: one-hot result and a found flag.

Test Plan:
- Reset, then eff=4'b1111 with no lock held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; plot high from cycle 2 onward; vga_x follows the granted requester's x.
- Requester 0 with req_lock=1 over 19200 pixels while requester 3 is requesting -> gnt[3]=0 throughout the burst. Drop lock on the last pixel -> next grant goes to requester 1 if eff[1]=1, else requester 3; lock_active falls after that edge.
- Requester 2 sends x=160,y=5 then x=159,y=119 -> first transfer gives plot=0, oob_drop=1; second gives plot=1, vga_x=159, vga_y=119.
- Requester 1 locked, then req_en[1] set to 0 mid-burst -> gnt[1]=0 that cycle, lock_active=0 next cycle, pointer=2.
- abort asserted in the same cycle as eff=4'b0110 -> gnt=0, next cycle plot=0 and pointer=0; following cycle gnt=0010.
- resetn pulsed low asynchronously between clock edges during a burst -> plot, lock_active and owner read 0 immediately, before the next edge.
